ex_mem_stage: RTL and testbench

Parametrised execute stage for the SIMPLE pipeline. It contains the ALU, operand forwarding muxes, a condition-flag register, and the EX/MEM pipeline register. Compared with the fixed 16-bit stage, it adds configurable width, a valid bit, stall/flush control, a flag register and forwarding. It sits between the register-read stage and the memory stage.

---
 rtl/ex_mem_stage.sv | 226 ++++++++++++++++++++++
 tb/tb_ex_mem_stage.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: execute stage of the SIMPLE pipeline.
// Holds the operand forwarding muxes, the ALU, the {S,Z,C,V} condition-flag
// register and the EX/MEM pipeline register. One cycle of latency from
// operands to registered result.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid, stall, flush    pipeline control (rst > flush > stall > advance)
//   alu1, alu2, storedata     operands from register read
//   fwd_sel1/2/_sd            forwarding selects (1 = fwd_mem, 2 = fwd_wb, else port)
//   fwd_mem, fwd_wb           results currently in the MEM and WB stages
//   opcode, set_flags         ALU operation and flag-update request
//   writereg, regaddress      destination register write enable / address
//   memwrite, address         memory write control / address
//   out_valid .. storeData    registered EX/MEM outputs
//   flags                     {S,Z,C,V} flag register
module ex_mem_stage #(
  parameter int DATA_W = 16,
  parameter int RA_W   = 3,
  parameter int SH_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic [DATA_W-1:0] alu1,
  input  logic [DATA_W-1:0] alu2,
  input  logic [3:0]        opcode,
  input  logic              set_flags,
  input  logic              writereg,
  input  logic [RA_W-1:0]   regaddress,
  input  logic [1:0]        memwrite,
  input  logic [DATA_W-1:0] address,
  input  logic [DATA_W-1:0] storedata,
  input  logic [1:0]        fwd_sel1,
  input  logic [1:0]        fwd_sel2,
  input  logic [1:0]        fwd_sel_sd,
  input  logic [DATA_W-1:0] fwd_mem,
  input  logic [DATA_W-1:0] fwd_wb,
  output logic              out_valid,
  output logic [DATA_W-1:0] aluOutput,
  output logic              writeReg,
  output logic [1:0]        memWrite,
  output logic [RA_W-1:0]   regAddress,
  output logic [DATA_W-1:0] Address,
  output logic [DATA_W-1:0] storeData,
  output logic [3:0]        flags
);

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_CMP = 4'd5,
    OP_MOV = 4'd6,
    OP_SLL = 4'd8,
    OP_SLR = 4'd9,
    OP_SRL = 4'd10,
    OP_SRA = 4'd11
  } op_e;

  // Width of the datapath expressed in shift-amount bits, used to build the
  // complementary shift of the rotate.
  localparam logic [SH_W:0] WIDTH_L = (SH_W + 1)'(DATA_W);

  function automatic logic [DATA_W-1:0] fwdMux(input logic [1:0]        sel,
                                               input logic [DATA_W-1:0] port,
                                               input logic [DATA_W-1:0] mem,
                                               input logic [DATA_W-1:0] wb);
    case (sel)
      2'd1:    return mem;
      2'd2:    return wb;
      default: return port;
    endcase
  endfunction

  logic [DATA_W-1:0] op1, op2, sdFwd;
  logic [SH_W-1:0]   shAmt;
  logic [DATA_W:0]   sum, diff, shl, shr, sra;
  logic [DATA_W-1:0] rot;
  logic [DATA_W-1:0] result;
  logic              carry, overflow, defined, flagOp;

  assign op1   = fwdMux(fwd_sel1,   alu1,      fwd_mem, fwd_wb);
  assign op2   = fwdMux(fwd_sel2,   alu2,      fwd_mem, fwd_wb);
  assign sdFwd = fwdMux(fwd_sel_sd, storedata, fwd_mem, fwd_wb);
  assign shAmt = op2[SH_W-1:0];

  // Shifts are done one bit wider than the datapath so the extra bit catches
  // the last bit shifted out; with a zero shift that bit stays 0, giving C=0.
  assign sum  = {1'b0, op1} + {1'b0, op2};
  assign diff = {1'b0, op1} - {1'b0, op2};
  assign shl  = {1'b0, op1} << shAmt;
  assign shr  = {op1, 1'b0} >> shAmt;
  assign sra  = $signed({op1, 1'b0}) >>> shAmt;
  assign rot  = (op1 << shAmt) | (op1 >> (WIDTH_L - {1'b0, shAmt}));

  // ALU: result plus carry/overflow candidates; flagOp marks operations that
  // are allowed to update the flag register.
  always_comb begin
    result   = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    defined  = 1'b1;
    flagOp   = 1'b1;
    case (opcode)
      OP_ADD: begin
        result   = sum[DATA_W-1:0];
        carry    = sum[DATA_W];
        overflow = (op1[DATA_W-1] == op2[DATA_W-1]) &&
                   (sum[DATA_W-1] != op1[DATA_W-1]);
      end
      OP_SUB, OP_CMP: begin
        result   = diff[DATA_W-1:0];
        carry    = diff[DATA_W];
        overflow = (op1[DATA_W-1] != op2[DATA_W-1]) &&
                   (diff[DATA_W-1] != op1[DATA_W-1]);
      end
      OP_AND: result = op1 & op2;
      OP_OR:  result = op1 | op2;
      OP_XOR: result = op1 ^ op2;
      OP_MOV: begin
        result = op2;
        flagOp = 1'b0;
      end
      OP_SLL: begin
        result = shl[DATA_W-1:0];
        carry  = shl[DATA_W];
      end
      OP_SLR: begin
        result = rot;
        carry  = (shAmt != '0) && rot[0];
      end
      OP_SRL: begin
        result = shr[DATA_W:1];
        carry  = shr[0];
      end
      OP_SRA: begin
        result = sra[DATA_W:1];
        carry  = sra[0];
      end
      default: begin
        defined = 1'b0;
        flagOp  = 1'b0;
      end
    endcase
  end

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] aluOut_q, aluOut_d;
  logic              writeReg_q, writeReg_d;
  logic [1:0]        memWrite_q, memWrite_d;
  logic [RA_W-1:0]   regAddr_q, regAddr_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] storeData_q, storeData_d;
  logic [3:0]        flags_q, flags_d;

  // Next state: flush (or an advancing bubble) clears the pipeline register
  // but keeps the flags; stall holds everything; a real instruction advances.
  always_comb begin
    valid_d     = valid_q;
    aluOut_d    = aluOut_q;
    writeReg_d  = writeReg_q;
    memWrite_d  = memWrite_q;
    regAddr_d   = regAddr_q;
    addr_d      = addr_q;
    storeData_d = storeData_q;
    flags_d     = flags_q;
    if (flush || (!stall && !in_valid)) begin
      valid_d     = 1'b0;
      aluOut_d    = '0;
      writeReg_d  = 1'b0;
      memWrite_d  = '0;
      regAddr_d   = '0;
      addr_d      = '0;
      storeData_d = '0;
    end else if (!stall) begin
      valid_d     = 1'b1;
      aluOut_d    = result;
      writeReg_d  = writereg && defined && (opcode != OP_CMP);
      memWrite_d  = memwrite;
      regAddr_d   = regaddress;
      addr_d      = address;
      storeData_d = sdFwd;
      if (set_flags && flagOp) begin
        flags_d = {result[DATA_W-1], (result == '0), carry, overflow};
      end
    end
  end

  // State register with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      aluOut_q    <= '0;
      writeReg_q  <= 1'b0;
      memWrite_q  <= '0;
      regAddr_q   <= '0;
      addr_q      <= '0;
      storeData_q <= '0;
      flags_q     <= '0;
    end else begin
      valid_q     <= valid_d;
      aluOut_q    <= aluOut_d;
      writeReg_q  <= writeReg_d;
      memWrite_q  <= memWrite_d;
      regAddr_q   <= regAddr_d;
      addr_q      <= addr_d;
      storeData_q <= storeData_d;
      flags_q     <= flags_d;
    end
  end

  assign out_valid  = valid_q;
  assign aluOutput  = aluOut_q;
  assign writeReg   = writeReg_q;
  assign memWrite   = memWrite_q;
  assign regAddress = regAddr_q;
  assign Address    = addr_q;
  assign storeData  = storeData_q;
  assign flags      = flags_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed bench for ex_mem_stage at DATA_W=16 and DATA_W=32.
// Both instances share the stimulus; each has its own expected-response queue,
// and a monitor compares the registered outputs one cycle after each issue.
module tb_ex_mem_stage;

  typedef struct packed {
    logic        rst, inValid, stall, flush, setFlags, writereg;
    logic [3:0]  opcode;
    logic [2:0]  ra;
    logic [1:0]  mw;
    logic [31:0] a, b, addr, sd;
    logic [1:0]  fs1, fs2, fsd;
    logic [31:0] fwdMem, fwdWb;
  } stim_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] alu;
    logic        wreg;
    logic [1:0]  mw;
    logic [2:0]  ra;
    logic [31:0] addr, sd;
    logic [3:0]  fl;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, inValid, stall, flush, setFlags, writereg;
  logic [3:0]  opcode;
  logic [2:0]  regaddress;
  logic [1:0]  memwrite, fs1, fs2, fsd;
  logic [31:0] alu1, alu2, address, storedata, fwdMem, fwdWb;

  logic        outValid16, writeReg16, outValid32, writeReg32;
  logic [15:0] aluOut16, addr16, sd16;
  logic [31:0] aluOut32, addr32, sd32;
  logic [1:0]  memWrite16, memWrite32;
  logic [2:0]  regAddr16, regAddr32;
  logic [3:0]  flags16, flags32;

  exp_t q16[$];
  exp_t q32[$];
  int   assertCount = 0;
  int   failCount   = 0;

  always #5 clk = ~clk;

  ex_mem_stage #(.DATA_W(16), .RA_W(3), .SH_W(4)) dut16 (
    .clk(clk), .rst(rst), .in_valid(inValid), .stall(stall), .flush(flush),
    .alu1(alu1[15:0]), .alu2(alu2[15:0]), .opcode(opcode), .set_flags(setFlags),
    .writereg(writereg), .regaddress(regaddress), .memwrite(memwrite),
    .address(address[15:0]), .storedata(storedata[15:0]),
    .fwd_sel1(fs1), .fwd_sel2(fs2), .fwd_sel_sd(fsd),
    .fwd_mem(fwdMem[15:0]), .fwd_wb(fwdWb[15:0]),
    .out_valid(outValid16), .aluOutput(aluOut16), .writeReg(writeReg16),
    .memWrite(memWrite16), .regAddress(regAddr16), .Address(addr16),
    .storeData(sd16), .flags(flags16));

  ex_mem_stage #(.DATA_W(32), .RA_W(3), .SH_W(5)) dut32 (
    .clk(clk), .rst(rst), .in_valid(inValid), .stall(stall), .flush(flush),
    .alu1(alu1), .alu2(alu2), .opcode(opcode), .set_flags(setFlags),
    .writereg(writereg), .regaddress(regaddress), .memwrite(memwrite),
    .address(address), .storedata(storedata),
    .fwd_sel1(fs1), .fwd_sel2(fs2), .fwd_sel_sd(fsd),
    .fwd_mem(fwdMem), .fwd_wb(fwdWb),
    .out_valid(outValid32), .aluOutput(aluOut32), .writeReg(writeReg32),
    .memWrite(memWrite32), .regAddress(regAddr32), .Address(addr32),
    .storeData(sd32), .flags(flags32));

  function automatic stim_t instr(input logic [3:0] op, input logic [31:0] a, b,
                                  input logic sf, wr, input logic [2:0] ra,
                                  input logic [1:0] mw, input logic [31:0] addr, sd);
    stim_t s;
    s = '0;
    s.inValid = 1'b1;
    s.opcode = op; s.a = a; s.b = b; s.setFlags = sf; s.writereg = wr;
    s.ra = ra; s.mw = mw; s.addr = addr; s.sd = sd;
    return s;
  endfunction

  function automatic exp_t expv(input logic v, input logic [31:0] alu, input logic wr,
                                input logic [1:0] mw, input logic [2:0] ra,
                                input logic [31:0] addr, sd, input logic [3:0] fl);
    exp_t e;
    e.valid = v; e.alu = alu; e.wreg = wr; e.mw = mw; e.ra = ra;
    e.addr = addr; e.sd = sd; e.fl = fl;
    return e;
  endfunction

  function automatic exp_t bubble(input logic [3:0] fl);
    return expv(1'b0, 32'h0, 1'b0, 2'd0, 3'd0, 32'h0, 32'h0, fl);
  endfunction

  // Drive one cycle of stimulus at the falling edge and queue its response.
  task automatic applyStimulus(input stim_t s, input exp_t e, input bit wide);
    @(negedge clk);
    rst = s.rst; inValid = s.inValid; stall = s.stall; flush = s.flush;
    setFlags = s.setFlags; writereg = s.writereg; opcode = s.opcode;
    regaddress = s.ra; memwrite = s.mw; alu1 = s.a; alu2 = s.b;
    address = s.addr; storedata = s.sd; fs1 = s.fs1; fs2 = s.fs2; fsd = s.fsd;
    fwdMem = s.fwdMem; fwdWb = s.fwdWb;
    if (wide) q32.push_back(e);
    else      q16.push_back(e);
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    assertCount++;
    if (act !== req) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic checkOutput(input string tag, input exp_t e, input exp_t a);
    cmp({tag, " out_valid"},  {31'b0, a.valid}, {31'b0, e.valid});
    cmp({tag, " aluOutput"},  a.alu,            e.alu);
    cmp({tag, " writeReg"},   {31'b0, a.wreg},  {31'b0, e.wreg});
    cmp({tag, " memWrite"},   {30'b0, a.mw},    {30'b0, e.mw});
    cmp({tag, " regAddress"}, {29'b0, a.ra},    {29'b0, e.ra});
    cmp({tag, " Address"},    a.addr,           e.addr);
    cmp({tag, " storeData"},  a.sd,             e.sd);
    cmp({tag, " flags"},      {28'b0, a.fl},    {28'b0, e.fl});
  endtask

  // Monitor: one cycle after every issued stimulus the registers have updated.
  initial begin
    exp_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (q16.size() > 0) begin
        e = q16.pop_front();
        a = expv(outValid16, {16'h0, aluOut16}, writeReg16, memWrite16, regAddr16,
                 {16'h0, addr16}, {16'h0, sd16}, flags16);
        checkOutput("w16", e, a);
      end
      if (q32.size() > 0) begin
        e = q32.pop_front();
        a = expv(outValid32, aluOut32, writeReg32, memWrite32, regAddr32,
                 addr32, sd32, flags32);
        checkOutput("w32", e, a);
      end
    end
  end

  initial begin
    stim_t s;
    exp_t  e, holdExp;
    rst = 1'b1; inValid = 1'b0; stall = 1'b0; flush = 1'b0; setFlags = 1'b0;
    writereg = 1'b0; opcode = 4'd0; regaddress = 3'd0; memwrite = 2'd0;
    alu1 = '0; alu2 = '0; address = '0; storedata = '0;
    fs1 = 2'd0; fs2 = 2'd0; fsd = 2'd0; fwdMem = '0; fwdWb = '0;

    // ---------------- 16-bit instance ----------------
    s = instr(4'd0, 32'h1, 32'h2, 1'b1, 1'b1, 3'd7, 2'd3, 32'h55, 32'h66);
    s.rst = 1'b1;
    applyStimulus(s, bubble(4'h0), 1'b0);
    applyStimulus(s, bubble(4'h0), 1'b0);
    applyStimulus(instr(4'd0, 32'h7FFF, 32'h0001, 1'b1, 1'b1, 3'd3, 2'd1, 32'h0100, 32'h1234),
                  expv(1'b1, 32'h8000, 1'b1, 2'd1, 3'd3, 32'h0100, 32'h1234, 4'h9), 1'b0);
    applyStimulus(instr(4'd1, 32'h0003, 32'h0005, 1'b1, 1'b1, 3'd4, 2'd0, 32'h0200, 32'h0055),
                  expv(1'b1, 32'hFFFE, 1'b1, 2'd0, 3'd4, 32'h0200, 32'h0055, 4'hA), 1'b0);
    applyStimulus(instr(4'd5, 32'h0005, 32'h0005, 1'b1, 1'b1, 3'd5, 2'd0, 32'h0000, 32'h0000),
                  expv(1'b1, 32'h0000, 1'b0, 2'd0, 3'd5, 32'h0, 32'h0, 4'h4), 1'b0);
    holdExp = expv(1'b1, 32'h3333, 1'b1, 2'd0, 3'd1, 32'h0010, 32'h00AA, 4'h4);
    applyStimulus(instr(4'd0, 32'h1111, 32'h2222, 1'b0, 1'b1, 3'd1, 2'd0, 32'h0010, 32'h00AA),
                  holdExp, 1'b0);
    // Stall three cycles while the inputs carry a different instruction.
    for (int i = 0; i < 3; i++) begin
      s = instr(4'd4, 32'hFFFF, 32'h0F0F + i, 1'b1, 1'b1, 3'd7, 2'd2, 32'h0300, 32'h0BEE);
      s.stall = 1'b1;
      applyStimulus(s, holdExp, 1'b0);
    end
    applyStimulus(instr(4'd4, 32'hFFFF, 32'h0F0F, 1'b1, 1'b1, 3'd7, 2'd2, 32'h0300, 32'h0BEE),
                  expv(1'b1, 32'hF0F0, 1'b1, 2'd2, 3'd7, 32'h0300, 32'h0BEE, 4'h8), 1'b0);
    s = instr(4'd0, 32'h1, 32'h1, 1'b1, 1'b1, 3'd2, 2'd1, 32'h9, 32'h9);
    s.stall = 1'b1; s.flush = 1'b1;
    applyStimulus(s, bubble(4'h8), 1'b0);
    // Forwarding.
    s = instr(4'd0, 32'h0AAA, 32'h0BBB, 1'b0, 1'b1, 3'd2, 2'd1, 32'h0400, 32'h0CCC);
    s.fs1 = 2'd1; s.fs2 = 2'd2; s.fsd = 2'd1; s.fwdMem = 32'h0010; s.fwdWb = 32'h0020;
    applyStimulus(s, expv(1'b1, 32'h0030, 1'b1, 2'd1, 3'd2, 32'h0400, 32'h0010, 4'h8), 1'b0);
    s.fs1 = 2'd3; s.fs2 = 2'd3; s.fsd = 2'd3;
    applyStimulus(s, expv(1'b1, 32'h1665, 1'b1, 2'd1, 3'd2, 32'h0400, 32'h0CCC, 4'h8), 1'b0);
    s = instr(4'd1, 32'h0AAA, 32'h0005, 1'b0, 1'b1, 3'd6, 2'd0, 32'h0500, 32'h0CCC);
    s.fs1 = 2'd2; s.fsd = 2'd2; s.fwdMem = 32'h0010; s.fwdWb = 32'h0020;
    applyStimulus(s, expv(1'b1, 32'h001B, 1'b1, 2'd0, 3'd6, 32'h0500, 32'h0020, 4'h8), 1'b0);
    // Shifts, rotate, undefined opcode, MOV and logic ops.
    applyStimulus(instr(4'd11, 32'h8001, 32'h1, 1'b1, 1'b1, 3'd6, 2'd0, 32'h0, 32'h0),
                  expv(1'b1, 32'hC000, 1'b1, 2'd0, 3'd6, 32'h0, 32'h0, 4'hA), 1'b0);
    applyStimulus(instr(4'd9, 32'h8001, 32'h4, 1'b1, 1'b1, 3'd6, 2'd0, 32'h0, 32'h0),
                  expv(1'b1, 32'h0018, 1'b1, 2'd0, 3'd6, 32'h0, 32'h0, 4'h0), 1'b0);
    applyStimulus(instr(4'd7, 32'h1234, 32'h5678, 1'b1, 1'b1, 3'd3, 2'd1, 32'h0700, 32'h0077),
                  expv(1'b1, 32'h0000, 1'b0, 2'd1, 3'd3, 32'h0700, 32'h0077, 4'h0), 1'b0);
    applyStimulus(instr(4'd8, 32'h8001, 32'h1, 1'b1, 1'b1, 3'd1, 2'd0, 32'h0, 32'h0),
                  expv(1'b1, 32'h0002, 1'b1, 2'd0, 3'd1, 32'h0, 32'h0, 4'h2), 1'b0);
    applyStimulus(instr(4'd10, 32'h0006, 32'h1, 1'b1, 1'b1, 3'd1, 2'd0, 32'h0, 32'h0),
                  expv(1'b1, 32'h0003, 1'b1, 2'd0, 3'd1, 32'h0, 32'h0, 4'h0), 1'b0);
    applyStimulus(instr(4'd6, 32'h1234, 32'h0000, 1'b1, 1'b1, 3'd2, 2'd0, 32'h0, 32'h0),
                  expv(1'b1, 32'h0000, 1'b1, 2'd0, 3'd2, 32'h0, 32'h0, 4'h0), 1'b0);
    applyStimulus(instr(4'd2, 32'hF0F0, 32'h0F0F, 1'b1, 1'b1, 3'd2, 2'd0, 32'h0, 32'h0),
                  expv(1'b1, 32'h0000, 1'b1, 2'd0, 3'd2, 32'h0, 32'h0, 4'h4), 1'b0);
    applyStimulus(instr(4'd3, 32'h8000, 32'h0001, 1'b1, 1'b1, 3'd2, 2'd0, 32'h0, 32'h0),
                  expv(1'b1, 32'h8001, 1'b1, 2'd0, 3'd2, 32'h0, 32'h0, 4'h8), 1'b0);
    s = instr(4'd0, 32'h1, 32'h1, 1'b1, 1'b1, 3'd4, 2'd1, 32'h1, 32'h1);
    s.inValid = 1'b0;
    applyStimulus(s, bubble(4'h8), 1'b0);
    applyStimulus(instr(4'd0, 32'hFFFF, 32'h0001, 1'b1, 1'b1, 3'd4, 2'd0, 32'h0, 32'h0),
                  expv(1'b1, 32'h0000, 1'b1, 2'd0, 3'd4, 32'h0, 32'h0, 4'h6), 1'b0);
    s.stall = 1'b1; s.rst = 1'b1;
    applyStimulus(s, bubble(4'h0), 1'b0);

    // ---------------- 32-bit instance ----------------
    s = instr(4'd0, 32'h1, 32'h2, 1'b1, 1'b1, 3'd7, 2'd3, 32'h55, 32'h66);
    s.rst = 1'b1;
    applyStimulus(s, bubble(4'h0), 1'b1);
    holdExp = expv(1'b1, 32'h80000000, 1'b1, 2'd1, 3'd1, 32'h10000000, 32'hDEADBEEF, 4'h9);
    applyStimulus(instr(4'd0, 32'h7FFFFFFF, 32'h1, 1'b1, 1'b1, 3'd1, 2'd1, 32'h10000000, 32'hDEADBEEF),
                  holdExp, 1'b1);
    s = instr(4'd1, 32'h5, 32'h9, 1'b1, 1'b1, 3'd2, 2'd2, 32'h0, 32'h0);
    s.stall = 1'b1;
    applyStimulus(s, holdExp, 1'b1);
    applyStimulus(instr(4'd11, 32'h80000001, 32'h1, 1'b1, 1'b1, 3'd2, 2'd0, 32'h0, 32'h0),
                  expv(1'b1, 32'hC0000000, 1'b1, 2'd0, 3'd2, 32'h0, 32'h0, 4'hA), 1'b1);
    applyStimulus(instr(4'd9, 32'h80000001, 32'h4, 1'b1, 1'b1, 3'd2, 2'd0, 32'h0, 32'h0),
                  expv(1'b1, 32'h00000018, 1'b1, 2'd0, 3'd2, 32'h0, 32'h0, 4'h0), 1'b1);
    applyStimulus(instr(4'd8, 32'h3, 32'd31, 1'b1, 1'b1, 3'd3, 2'd0, 32'h0, 32'h0),
                  expv(1'b1, 32'h80000000, 1'b1, 2'd0, 3'd3, 32'h0, 32'h0, 4'hA), 1'b1);
    applyStimulus(instr(4'd7, 32'h1234, 32'h1, 1'b1, 1'b1, 3'd3, 2'd0, 32'h0, 32'h0),
                  expv(1'b1, 32'h0, 1'b0, 2'd0, 3'd3, 32'h0, 32'h0, 4'hA), 1'b1);
    applyStimulus(instr(4'd1, 32'h80000000, 32'h1, 1'b1, 1'b1, 3'd5, 2'd0, 32'h0, 32'h0),
                  expv(1'b1, 32'h7FFFFFFF, 1'b1, 2'd0, 3'd5, 32'h0, 32'h0, 4'h1), 1'b1);
    s = instr(4'd0, 32'h1, 32'h1, 1'b1, 1'b1, 3'd5, 2'd1, 32'h1, 32'h1);
    s.flush = 1'b1;
    applyStimulus(s, bubble(4'h1), 1'b1);

    // Drain the queues within a bounded number of cycles.
    for (int i = 0; i < 20 && (q16.size() + q32.size()) > 0; i++) @(posedge clk);
    #2;
    assertCount++;
    if ((q16.size() + q32.size()) != 0) begin
      failCount++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", q16.size() + q32.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
